// File: rtl/rr_prio_encoder.sv
// Priority encoder with fixed (lowest-index-first) and round-robin modes.
// The request vector is accepted through a valid/ready handshake. The selection
// is combinational from (in, mode, ptr). The result is held in a one-entry
// output register until the consumer takes it.
module rr_prio_encoder #(
    parameter int WIDTH = 8,
    parameter int POSW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [POSW-1:0]  pos,
    output logic             none
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [POSW-1:0]   r_ptr;
    logic [POSW-1:0]   r_pos;
    logic              r_none;

    logic              w_accept;
    logic              w_out_hs;
    logic [POSW-1:0]   w_base;
    logic [WIDTH-1:0]  w_rot;
    logic [POSW-1:0]   w_idx [WIDTH];
    logic [POSW-1:0]   w_off;
    logic [POSW-1:0]   w_sel;
    logic              w_none;

    // The register can take a new vector when it is empty or is being drained this cycle.
    assign in_ready  = (r_state == S_EMPTY) || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_out_hs  = (r_state == S_FULL) && out_ready;
    assign out_valid = (r_state == S_FULL);
    assign pos       = r_pos;
    assign none      = r_none;

    // Fixed mode is a round-robin scan that always starts at index 0.
    assign w_base = mode ? r_ptr : '0;
    assign w_none = (in == '0);

    // Rotate the request vector so that bit w_base lands at position 0.
    // POSW-bit addition wraps modulo WIDTH because WIDTH is a power of two.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rot
            localparam logic [POSW-1:0] K = POSW'(gi);
            assign w_idx[gi] = w_base + K;
            assign w_rot[gi] = in[w_idx[gi]];
        end
    endgenerate

    // Lowest set bit of the rotated vector; scanning downward lets the smallest offset win.
    always_comb begin
        w_off = '0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = POSW'(k);
            end
        end
    end

    // Undo the rotation to get the absolute index.
    assign w_sel = w_base + w_off;

    // Output FSM next state: fill on acceptance, drain on handshake without a refill.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_state_next = S_FULL;
                end
            end
            S_FULL: begin
                if (w_out_hs && !w_accept) begin
                    w_state_next = S_EMPTY;
                end
            end
            default: begin
                w_state_next = S_EMPTY;
            end
        endcase
    end

    // Output FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Result register: loaded only on acceptance, so it holds steady while stalled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pos  <= '0;
            r_none <= 1'b0;
        end else if (w_accept) begin
            r_pos  <= w_none ? '0 : w_sel;
            r_none <= w_none;
        end
    end

    // Round-robin pointer: moves just past the winner, only for nonzero round-robin requests.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ptr <= '0;
        end else if (w_accept && mode && !w_none) begin
            r_ptr <= w_sel + POSW'(1);
        end
    end

endmodule

// File: tb/tb_rr_prio_encoder.sv
// Self-checking bench for rr_prio_encoder (WIDTH=8) using a scoreboard queue.
module tb_rr_prio_encoder;

    localparam int W = 8;
    localparam int PW = 3;

    logic          clk;
    logic          resetn;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_vec;
    logic          mode;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] pos;
    logic          none;

    typedef struct packed {
        logic [PW-1:0] pos;
        logic          none;
    } exp_t;

    exp_t exp_q[$];
    int   m_ptr;
    int   n_tests;
    int   n_fail;

    rr_prio_encoder #(.WIDTH(W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_vec),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pos       (pos),
        .none      (none)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            $display("[TB] ok   %s: %0h at %0t", tag, got, $time);
        end
    endtask

    // Reference selection: search the doubled vector from the start index.
    function automatic exp_t model(input logic [W-1:0] v, input logic m, input int p);
        exp_t r;
        logic [2*W-1:0] dbl;
        int base;
        int k;
        r.pos  = '0;
        r.none = 1'b1;
        if (v != '0) begin
            base = m ? p : 0;
            dbl  = {v, v};
            k    = 0;
            while (!dbl[base + k]) k++;
            r.pos  = PW'((base + k) % W);
            r.none = 1'b0;
        end
        return r;
    endfunction

    // Scoreboard monitor: samples handshakes on the falling edge, flushes on reset.
    initial begin
        exp_t e;
        exp_t got;
        m_ptr = 0;
        forever begin
            @(negedge clk or negedge resetn);
            if (!resetn) begin
                exp_q.delete();
                m_ptr = 0;
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("sb_underflow", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        got.pos  = pos;
                        got.none = none;
                        check_eq("sb_pos", 64'(got.pos), 64'(e.pos));
                        check_eq("sb_none", 64'(got.none), 64'(e.none));
                    end
                end
                if (in_valid && in_ready) begin
                    e = model(in_vec, mode, m_ptr);
                    exp_q.push_back(e);
                    if (mode && !e.none) m_ptr = (int'(e.pos) + 1) % W;
                end
            end
        end
    end

    task automatic drive(input logic iv, input logic [W-1:0] v, input logic m, input logic ordy);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_vec    = v;
        mode      = m;
        out_ready = ordy;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_vec    = '0;
        mode      = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #2;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_pos", 64'(pos), 64'd0);
        check_eq("rst_none", 64'(none), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_ptr", 64'(dut.r_ptr), 64'd0);
        @(posedge clk);
        #3 resetn = 1'b1;

        // Fixed mode, lowest index first
        drive(1'b1, 8'b0110_1000, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("fix_out_valid", 64'(out_valid), 64'd1);
        check_eq("fix_pos", 64'(pos), 64'd3);
        check_eq("fix_ptr", 64'(dut.r_ptr), 64'd0);

        // Round-robin rotation, back-to-back
        for (int i = 0; i < 3; i++) drive(1'b1, 8'hFF, 1'b1, 1'b1);
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        check_eq("rr_pos_last", 64'(pos), 64'd2);
        check_eq("rr_ptr", 64'(dut.r_ptr), 64'd3);

        // Advance ptr to 6, then wrap cases
        for (int i = 0; i < 3; i++) drive(1'b1, 8'hFF, 1'b1, 1'b1);
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        check_eq("wrap_ptr6", 64'(dut.r_ptr), 64'd6);
        drive(1'b1, 8'b0000_0101, 1'b1, 1'b1);
        drive(1'b1, 8'b1000_0000, 1'b1, 1'b1);
        check_eq("wrap_pos0", 64'(pos), 64'd0);
        check_eq("wrap_ptr1", 64'(dut.r_ptr), 64'd1);
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        check_eq("wrap_pos7", 64'(pos), 64'd7);
        check_eq("wrap_ptr0", 64'(dut.r_ptr), 64'd0);

        // All-zero input with ptr=5
        for (int i = 0; i < 5; i++) drive(1'b1, 8'hFF, 1'b1, 1'b1);
        drive(1'b1, 8'h00, 1'b1, 1'b1);
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        check_eq("zero_none", 64'(none), 64'd1);
        check_eq("zero_pos", 64'(pos), 64'd0);
        check_eq("zero_ptr", 64'(dut.r_ptr), 64'd5);

        // Backpressure: hold for 4 cycles, then drain and refill in one cycle
        drive(1'b1, 8'b0001_0100, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'b1000_0000, 1'b0, 1'b0);
            check_eq("bp_in_ready", 64'(in_ready), 64'd0);
            check_eq("bp_pos_hold", 64'(pos), 64'd2);
            check_eq("bp_none_hold", 64'(none), 64'd0);
        end
        drive(1'b1, 8'b1000_0000, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("bp_valid_kept", 64'(out_valid), 64'd1);
        check_eq("bp_new_pos", 64'(pos), 64'd7);

        // Reset mid-operation: FULL with pos=5, ptr=6
        drive(1'b1, 8'b0010_0000, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("mid_pre_pos", 64'(pos), 64'd5);
        check_eq("mid_pre_ptr", 64'(dut.r_ptr), 64'd6);
        #1 resetn = 1'b0;
        #1;
        check_eq("mid_out_valid", 64'(out_valid), 64'd0);
        check_eq("mid_pos", 64'(pos), 64'd0);
        check_eq("mid_ptr", 64'(dut.r_ptr), 64'd0);
        check_eq("mid_in_ready", 64'(in_ready), 64'd1);
        #1 resetn = 1'b1;
        drive(1'b1, 8'hFF, 1'b1, 1'b1);
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        check_eq("post_rst_pos", 64'(pos), 64'd0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) drive(1'b0, 8'h00, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check_eq("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_prio_encoder.md
RR_PRIO_ENCODER -- requirements
Module: rr_prio_encoder

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, request vector width; legal values are powers of two, 2..64.
REQ-002 SHALL have derived parameter: POSW, default $clog2(WIDTH), width of the encoded position.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port: resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: in_valid  input  1  the request vector is presented.
REQ-006 SHALL have port: in_ready  output  1  the block accepts the request vector this cycle.
REQ-007 SHALL have port: in  input  WIDTH  request vector; bit i set means requester i is active.
REQ-008 SHALL have port: mode  input  1  priority mode: 0 = fixed lowest-index-first, 1 = round-robin; sampled on acceptance.
REQ-009 SHALL have port: out_valid  output  1  the result register holds a result.
REQ-010 SHALL have port: out_ready  input  1  the consumer takes the result this cycle.
REQ-011 SHALL have port: pos  output  POSW  index of the selected set bit.
REQ-012 SHALL have port: none  output  1  the accepted vector was all zeros.

Function
REQ-013 SHALL define acceptance as the cycle where in_valid && in_ready; in_ready = !out_valid || out_ready, combinational.
REQ-014 SHALL update the result register (pos, none, out_valid=1) on the clock edge ending the acceptance cycle; latency is 1 cycle.
REQ-015 SHALL define output handshake as out_valid && out_ready; it clears out_valid unless a new acceptance occurs in the same cycle, in which case out_valid stays 1 with new data.
REQ-016 SHALL hold pos and none stable while out_valid=1 and out_ready=0.
REQ-017 SHALL implement a two-state output FSM: EMPTY (out_valid=0) -> FULL on acceptance; FULL -> EMPTY on output handshake without acceptance; FULL -> FULL on handshake with acceptance or on stall.
REQ-018 SHALL, in mode 0, set pos to the lowest index i with in[i]=1.
REQ-019 SHALL keep an internal pointer ptr, POSW bits wide.
REQ-020 SHALL, in mode 1, set pos to the first set index found scanning ptr, ptr+1, ... upward with wrap modulo WIDTH.
REQ-021 SHALL, in mode 1 with in nonzero, set ptr to (pos+1) mod WIDTH on acceptance; WIDTH-1 wraps to 0.
REQ-022 SHALL leave ptr unchanged in mode 0, on all-zero input, and in cycles without acceptance.
REQ-023 SHALL, for all-zero in, set none=1 and pos=0 in either mode; otherwise none=0.
REQ-024 SHALL allow mode to change between any two acceptances with no flush; the next acceptance uses the current ptr.
REQ-025 SHALL compute the selection combinationally from in, mode and ptr; no multi-cycle search.

Reset
REQ-026 SHALL, while resetn=0, immediately force out_valid=0, pos=0, none=0 and ptr=0, independent of clk.
REQ-027 SHALL, while resetn=0, drive in_ready=1 (register empty); no acceptance is recorded while reset is asserted.
REQ-028 SHALL discard any held result when reset is asserted mid-operation; after deassertion the first acceptance behaves as after power-up.

Verification
REQ-029 SHALL verify fixed mode (WIDTH=8, mode=0, out_ready=1): accept in=8'b0110_1000 -> next cycle out_valid=1, pos=3, none=0; ptr stays 0.
REQ-030 SHALL verify round-robin rotation (mode=1): accept in=8'hFF three times back-to-back with out_ready=1 -> pos=0, 1, 2 on consecutive cycles; ptr=3 afterwards.
REQ-031 SHALL verify round-robin wrap (mode=1, ptr=6): accept in=8'b0000_0101 -> pos=0, ptr becomes 1; then accept in=8'b1000_0000 -> pos=7, ptr becomes 0.
REQ-032 SHALL verify all-zero input: accept in=0 in mode 1 with ptr=5 -> pos=0, none=1, ptr stays 5.
REQ-033 SHALL verify backpressure: result held with out_ready=0 for 4 cycles -> in_ready=0, pos/none unchanged; out_ready=1 with in_valid=1 -> handshake and acceptance in the same cycle, out_valid stays 1 with new data.
REQ-034 SHALL verify reset mid-operation: FULL with pos=5, ptr=6, then resetn pulsed low between clock edges -> out_valid=0, pos=0, ptr=0 at once; next accept in=8'hFF in mode 1 -> pos=0.
